// File: rtl/display_barrido_if.sv
// display_barrido_if: data/control inputs and scan outputs of the 7-segment scan driver
interface display_barrido_if #(
    parameter int N_DIGITS = 4
);
    logic [4*N_DIGITS-1:0] dato_i;
    logic                  load_i;
    logic                  blank_lz_i;
    logic [3:0]            cuenta_o;
    logic [N_DIGITS-1:0]   digit_en_o;
    logic                  blank_o;
    logic                  frame_o;

    modport master (
        output dato_i, load_i, blank_lz_i,
        input  cuenta_o, digit_en_o, blank_o, frame_o
    );

    modport slave (
        input  dato_i, load_i, blank_lz_i,
        output cuenta_o, digit_en_o, blank_o, frame_o
    );
endinterface

// File: rtl/display_barrido.sv
// display_barrido: 7-segment scan driver with dead time, leading-zero blanking and frame-aligned updates
module display_barrido #(
    parameter int N_DIGITS         = 4,
    parameter int PRESCALE         = 50000,
    parameter int BLANK_CYC        = 16,
    parameter int ANODE_ACTIVE_LOW = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    display_barrido_if.slave bus
);
    localparam int W  = 4 * N_DIGITS;
    localparam int CW = $clog2((PRESCALE > BLANK_CYC ? PRESCALE : BLANK_CYC) + 1);
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [N_DIGITS-1:0] OFF = {N_DIGITS{ANODE_ACTIVE_LOW != 0}};

    typedef enum logic {BLANK, SHOW} state_t;

    state_t              state, state_n;
    logic [CW-1:0]       cnt, cnt_n;
    logic [IW-1:0]       idx, idx_n;
    logic [W-1:0]        active, active_n, pending, pending_n;
    logic                pend_v, pend_v_n, lit, frame_n;
    logic [3:0]          nib_n;
    logic [N_DIGITS-1:0] en_n;

    // next state, data hand-over and output values as they must appear after the next edge
    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        idx_n   = idx;
        if (state == BLANK) begin
            if (cnt == CW'(BLANK_CYC - 1)) begin
                state_n = SHOW;
                cnt_n   = '0;
            end
        end else if (cnt == CW'(PRESCALE - 1)) begin
            state_n = BLANK;
            cnt_n   = '0;
            idx_n   = (idx == IW'(N_DIGITS - 1)) ? '0 : idx + 1'b1;
        end
        pending_n = bus.load_i ? bus.dato_i : pending;
        pend_v_n  = (bus.load_i | pend_v) & ~bus.frame_o;
        active_n  = !bus.frame_o ? active : bus.load_i ? bus.dato_i : pend_v ? pending : active;
        nib_n     = 4'(active_n >> {idx_n, 2'b00});
        lit       = state_n == SHOW &&
                    !(bus.blank_lz_i && idx_n != '0 && (active_n >> {idx_n, 2'b00}) == '0);
        en_n      = lit ? OFF ^ (N_DIGITS'(1) << idx_n) : OFF;
        frame_n   = state_n == SHOW && cnt_n == CW'(PRESCALE - 1) && idx_n == IW'(N_DIGITS - 1);
    end

    // state and registered outputs; outputs are loaded from next-state values so they line up with the FSM
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state          <= BLANK;
            cnt            <= '0;
            idx            <= '0;
            active         <= '0;
            pending        <= '0;
            pend_v         <= 1'b0;
            bus.cuenta_o   <= '0;
            bus.digit_en_o <= OFF;
            bus.blank_o    <= 1'b1;
            bus.frame_o    <= 1'b0;
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            idx            <= idx_n;
            active         <= active_n;
            pending        <= pending_n;
            pend_v         <= pend_v_n;
            bus.cuenta_o   <= nib_n;
            bus.digit_en_o <= en_n;
            bus.blank_o    <= !lit;
            bus.frame_o    <= frame_n;
        end
    end
endmodule

// File: tb/tb_display_barrido.sv
// tb_display_barrido: scoreboard bench; stimulus queues expected frames, a monitor checks each completed scan
module tb_display_barrido;
    localparam int N = 4;
    localparam int P = 4;
    localparam int B = 2;

    typedef struct packed {
        logic [3:0]  mask;
        logic [15:0] nib;
    } frame_t;

    logic   clk_i  = 1'b0;
    logic   rst_ni = 1'b0;
    int     n_chk  = 0;
    int     n_pass = 0;
    frame_t exp_q[$];

    always #5 clk_i = ~clk_i;

    display_barrido_if #(.N_DIGITS(N)) bus ();

    display_barrido #(
        .N_DIGITS(N), .PRESCALE(P), .BLANK_CYC(B), .ANODE_ACTIVE_LOW(1)
    ) dut (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    endtask

    task automatic drive_tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic load(input logic [15:0] v);
        drive_tick();
        bus.dato_i = v;
        bus.load_i = 1'b1;
        drive_tick();
        bus.load_i = 1'b0;
    endtask

    task automatic wait_frame();
        logic seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk_i);
            seen = bus.frame_o;
        end
        check("frame_timeout", 32'(seen), 32'd1);
    endtask

    task automatic wait_en(input logic [3:0] v);
        logic seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk_i);
            seen = bus.digit_en_o == v;
        end
        check("en_timeout", 32'(seen), 32'd1);
    endtask

    task automatic reset_seq();
        logic [3:0] tbl [9] = '{4'b1111, 4'b1111, 4'b1110, 4'b1110, 4'b1110,
                                4'b1110, 4'b1111, 4'b1111, 4'b1101};
        drive_tick();
        rst_ni = 1'b0;
        #1;
        check("rst_cuenta", 32'(bus.cuenta_o), 32'd0);
        check("rst_en", 32'(bus.digit_en_o), 32'hf);
        check("rst_blank", 32'(bus.blank_o), 32'd1);
        check("rst_frame", 32'(bus.frame_o), 32'd0);
        exp_q.push_back('{mask: 4'hf, nib: 16'h0000});
        drive_tick();
        drive_tick();
        rst_ni = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk_i);
            check($sformatf("release_en%0d", i), 32'(bus.digit_en_o), 32'(tbl[i]));
        end
    endtask

    // monitor: accumulates lit digits over a scan and compares against the queue on frame_o
    initial begin
        logic [3:0]  m_mask = '0;
        logic [15:0] m_nib  = '0;
        int          cyc    = 0;
        frame_t      e;
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                m_mask = '0;
                m_nib  = '0;
                cyc    = 0;
            end else begin
                cyc++;
                check("onehot", 32'($countones(~bus.digit_en_o) <= 1), 32'd1);
                check("blank_vs_en", 32'(bus.blank_o), 32'(bus.digit_en_o == 4'b1111));
                for (int k = 0; k < N; k++) begin
                    if (!bus.digit_en_o[k]) begin
                        if (m_mask[k]) check("cuenta_hold", 32'(bus.cuenta_o), 32'(m_nib[4*k +: 4]));
                        m_mask[k]       = 1'b1;
                        m_nib[4*k +: 4] = bus.cuenta_o;
                    end
                end
                if (bus.frame_o) begin
                    check("frame_period", 32'(cyc), 32'd24);
                    cyc = 0;
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        $display("FAIL frame_unexpected: got %h, expected none", {m_mask, m_nib});
                    end else begin
                        e = exp_q.pop_front();
                        check("frame", 32'({m_mask, m_nib}), 32'(e));
                    end
                    m_mask = '0;
                    m_nib  = '0;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    // stimulus: directed frames with hand-computed expectations
    initial begin
        bus.dato_i     = '0;
        bus.load_i     = 1'b0;
        bus.blank_lz_i = 1'b0;
        reset_seq();
        exp_q.push_back('{mask: 4'hf, nib: 16'h1234});
        load(16'h1234);
        wait_frame();
        wait_en(4'b1101);
        exp_q.push_back('{mask: 4'hf, nib: 16'hABCD});
        load(16'hABCD);
        wait_frame();
        exp_q.push_back('{mask: 4'hf, nib: 16'h5A5A});
        wait_frame();
        bus.dato_i = 16'h5A5A;
        bus.load_i = 1'b1;
        drive_tick();
        bus.load_i = 1'b0;
        exp_q.push_back('{mask: 4'b0011, nib: 16'h0050});
        load(16'h0050);
        wait_frame();
        bus.blank_lz_i = 1'b1;
        exp_q.push_back('{mask: 4'b0001, nib: 16'h0000});
        load(16'h0000);
        wait_frame();
        exp_q.push_back('{mask: 4'hf, nib: 16'h0000});
        wait_frame();
        bus.blank_lz_i = 1'b0;
        load(16'h1234);
        wait_frame();
        wait_en(4'b1011);
        reset_seq();
        wait_frame();
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
